// File: rtl/turn_signal_controller_pkg.sv
// Shared mode encodings, lamp patterns and request arbitration for the turn-signal controller.
package turn_signal_controller_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_t;

  localparam logic [2:0] PAT0 = 3'b000;
  localparam logic [2:0] PAT1 = 3'b001;
  localparam logic [2:0] PAT2 = 3'b011;
  localparam logic [2:0] PAT3 = 3'b111;

  // Lamp pattern {C,B,A} for a sequencer phase.
  function automatic logic [2:0] phase_pattern(input logic [1:0] phase);
    logic [2:0] pat;
    case (phase)
      2'd0:    pat = PAT0;
      2'd1:    pat = PAT1;
      2'd2:    pat = PAT2;
      default: pat = PAT3;
    endcase
    return pat;
  endfunction

  // Both turn requests at once are treated as a hazard request.
  function automatic mode_t arbitrate(input logic left, input logic right, input logic hazard);
    mode_t m;
    if (hazard || (left && right)) m = MODE_HAZARD;
    else if (left)                 m = MODE_LEFT;
    else if (right)                m = MODE_RIGHT;
    else                           m = MODE_IDLE;
    return m;
  endfunction

endpackage

// File: rtl/turn_signal_controller_light_sequencer.sv
// One three-lamp group: 2-bit phase counter with a registered lamp decode.
module light_sequencer
  import turn_signal_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  input  logic       enable,
  output logic [2:0] lamps,
  output logic       last
);

  logic [1:0] phase;
  logic [1:0] phase_nxt;

  always_comb begin
    phase_nxt = phase;
    if (clear)     phase_nxt = 2'd0;
    else if (step) phase_nxt = phase + 2'd1;
  end

  // Lamps decode the next phase so they line up with the phase register on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= 2'd0;
      lamps <= PAT0;
    end else begin
      phase <= phase_nxt;
      lamps <= enable ? phase_pattern(phase_nxt) : PAT0;
    end
  end

  assign last = (phase == 2'd3);

endmodule

// File: rtl/turn_signal_controller.sv
// Turn-signal top: step prescaler, mode FSM with arbitration, and two lamp sequencers.
//   state       | meaning
//   MODE_IDLE   | no request, lamps dark, arbitrating every cycle
//   MODE_LEFT   | left group sequencing, hazard preempts
//   MODE_RIGHT  | right group sequencing, hazard preempts
//   MODE_HAZARD | both groups sequencing in lockstep
module turn_signal_controller
  import turn_signal_controller_pkg::*;
#(
  parameter int TICK_DIV  = 12500000,
  parameter int DIV_WIDTH = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  output logic LA,
  output logic LB,
  output logic LC,
  output logic RA,
  output logic RB,
  output logic RC,
  output logic busy
);

  mode_t                mode;
  mode_t                mode_nxt;
  mode_t                req;
  logic [DIV_WIDTH-1:0] presc;
  logic                 tick;
  logic                 seq_end;
  logic                 restart;
  logic                 step;
  logic                 en_left;
  logic                 en_right;
  logic                 left_last;
  logic                 right_last;
  logic [2:0]           lamps_left;
  logic [2:0]           lamps_right;

  always_comb begin
    req      = arbitrate(left, right, hazard);
    tick     = (mode != MODE_IDLE) && (presc == DIV_WIDTH'(TICK_DIV - 1));
    // Both sequencers restart together, so the left one tracks hazard phase too.
    seq_end  = tick && ((mode == MODE_RIGHT) ? right_last : left_last);
    mode_nxt = mode;
    restart  = 1'b0;
    unique case (mode)
      MODE_IDLE: begin
        mode_nxt = req;
        restart  = 1'b1;
      end
      MODE_LEFT, MODE_RIGHT: begin
        if (hazard) begin
          mode_nxt = MODE_HAZARD;
          restart  = 1'b1;
        end else if (seq_end) begin
          mode_nxt = req;
          restart  = 1'b1;
        end
      end
      MODE_HAZARD: begin
        if (seq_end) begin
          mode_nxt = req;
          restart  = 1'b1;
        end
      end
    endcase
    step     = tick && !restart;
    en_left  = (mode_nxt == MODE_LEFT)  || (mode_nxt == MODE_HAZARD);
    en_right = (mode_nxt == MODE_RIGHT) || (mode_nxt == MODE_HAZARD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode  <= MODE_IDLE;
      busy  <= 1'b0;
      presc <= '0;
    end else begin
      mode  <= mode_nxt;
      busy  <= (mode_nxt != MODE_IDLE);
      presc <= (restart || tick) ? '0 : presc + DIV_WIDTH'(1);
    end
  end

  light_sequencer u_seq_left (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart),
    .step   (step),
    .enable (en_left),
    .lamps  (lamps_left),
    .last   (left_last)
  );

  light_sequencer u_seq_right (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart),
    .step   (step),
    .enable (en_right),
    .lamps  (lamps_right),
    .last   (right_last)
  );

  assign {LC, LB, LA} = lamps_left;
  assign {RC, RB, RA} = lamps_right;

endmodule
